// File: rtl/bcd_updown_display.sv
// Parametrised BCD up/down counter with load, wrap pulse and a multiplexed seven-segment driver.
// Optional leading-zero blanking is enabled by defining BCD_DISP_LZ_BLANK_EN.
module bcd_updown_display #(
    parameter int unsigned DIGITS    = 2,
    parameter int unsigned MAX_COUNT = 99,
    parameter int unsigned SCAN_DIV  = 1000
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  en,
    input  logic                  updown,
    input  logic                  load,
    input  logic [4*DIGITS-1:0]   load_val,
    output logic [4*DIGITS-1:0]   count,
    output logic                  tc,
    output logic [7:0]            seg,
    output logic [DIGITS-1:0]     an
);

    localparam int unsigned CW    = 4 * DIGITS;
    localparam int unsigned IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int unsigned PS_W  = $clog2(SCAN_DIV);

    function automatic logic [CW-1:0] to_bcd(input int unsigned v);
        logic [CW-1:0] r;
        int unsigned   x;
        r = '0;
        x = v;
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x           = x / 10;
        end
        return r;
    endfunction

    function automatic logic [7:0] seg_decode(input logic [3:0] n);
        case (n)
            4'd0:    return 8'b0000_0011;
            4'd1:    return 8'b1001_1111;
            4'd2:    return 8'b0010_0101;
            4'd3:    return 8'b0000_1101;
            4'd4:    return 8'b1001_1001;
            4'd5:    return 8'b0100_1001;
            4'd6:    return 8'b0100_0001;
            4'd7:    return 8'b0001_1111;
            4'd8:    return 8'b0000_0001;
            4'd9:    return 8'b0000_1001;
            default: return 8'b1111_1111;
        endcase
    endfunction

    localparam logic [CW-1:0] MAX_BCD = to_bcd(MAX_COUNT);

    logic [CW-1:0]     count_q, count_d;
    logic              tc_q, tc_d;
    logic [PS_W-1:0]   ps_q, ps_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DIGITS-1:0] an_q, an_d;
    logic [7:0]        seg_q, seg_d;

    logic              load_ok;
    logic [CW-1:0]     inc_val, dec_val;
    logic              carry, borrow;
    logic [3:0]        nib;

    // With every nibble <= 9, BCD ordering equals plain binary ordering.
    always_comb begin
        load_ok = (load_val <= MAX_BCD);
        for (int i = 0; i < DIGITS; i++) begin
            if (load_val[4*i +: 4] > 4'd9) load_ok = 1'b0;
        end
    end

    // Decimal increment/decrement with ripple carry/borrow across nibbles.
    always_comb begin
        inc_val = count_q;
        dec_val = count_q;
        carry   = 1'b1;
        borrow  = 1'b1;
        for (int i = 0; i < DIGITS; i++) begin
            if (carry) begin
                if (count_q[4*i +: 4] == 4'd9) begin
                    inc_val[4*i +: 4] = 4'd0;
                end else begin
                    inc_val[4*i +: 4] = count_q[4*i +: 4] + 4'd1;
                    carry             = 1'b0;
                end
            end
            if (borrow) begin
                if (count_q[4*i +: 4] == 4'd0) begin
                    dec_val[4*i +: 4] = 4'd9;
                end else begin
                    dec_val[4*i +: 4] = count_q[4*i +: 4] - 4'd1;
                    borrow            = 1'b0;
                end
            end
        end
    end

    // Counter next state: load beats en; an invalid load still blocks en.
    always_comb begin
        count_d = count_q;
        tc_d    = 1'b0;
        if (load) begin
            if (load_ok) count_d = load_val;
        end else if (en) begin
            if (!updown) begin
                if (count_q == MAX_BCD) begin
                    count_d = '0;
                    tc_d    = 1'b1;
                end else begin
                    count_d = inc_val;
                end
            end else begin
                if (count_q == '0) begin
                    count_d = MAX_BCD;
                    tc_d    = 1'b1;
                end else begin
                    count_d = dec_val;
                end
            end
        end
    end

    // an and seg are both built from the next index so they switch on the same edge.
    always_comb begin
        ps_d  = ps_q + PS_W'(1);
        idx_d = idx_q;
        if (ps_q == PS_W'(SCAN_DIV - 1)) begin
            ps_d = '0;
            if (idx_q == IDX_W'(DIGITS - 1)) idx_d = '0;
            else                             idx_d = idx_q + IDX_W'(1);
        end
        an_d = ~(DIGITS'(1) << idx_d);
        nib  = 4'd0;
        for (int i = 0; i < DIGITS; i++) begin
            if (idx_d == IDX_W'(i)) nib = count_q[4*i +: 4];
        end
    end

`ifdef BCD_DISP_LZ_BLANK_EN
    logic blank;

    // Blank digit k>=1 when it and every higher nibble are zero.
    always_comb begin
        blank = (idx_d != '0);
        for (int i = 0; i < DIGITS; i++) begin
            if ((IDX_W'(i) >= idx_d) && (count_q[4*i +: 4] != 4'd0)) blank = 1'b0;
        end
        seg_d = blank ? 8'b1111_1111 : seg_decode(nib);
    end
`else
    always_comb begin
        seg_d = seg_decode(nib);
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
            tc_q    <= 1'b0;
            ps_q    <= '0;
            idx_q   <= '0;
            an_q    <= ~DIGITS'(1);
            seg_q   <= 8'b0000_0011;
        end else begin
            count_q <= count_d;
            tc_q    <= tc_d;
            ps_q    <= ps_d;
            idx_q   <= idx_d;
            an_q    <= an_d;
            seg_q   <= seg_d;
        end
    end

    assign count = count_q;
    assign tc    = tc_q;
    assign seg   = seg_q;
    assign an    = an_q;

endmodule

// File: tb/tb_bcd_updown_display.sv
// Directed bench for bcd_updown_display: two instances (MAX_COUNT 99 and 59) sharing stimulus.
module tb_bcd_updown_display;

    logic       clk = 1'b0;
    logic       reset, en, updown, load;
    logic [7:0] load_val;
    logic [7:0] count0, count1, seg0, seg1;
    logic       tc0, tc1;
    logic [1:0] an0, an1;

    int checks = 0;
    int fails  = 0;
    int edges  = 0;

    always #5 clk = ~clk;

    bcd_updown_display #(.DIGITS(2), .MAX_COUNT(99), .SCAN_DIV(4)) u0 (
        .clk(clk), .reset(reset), .en(en), .updown(updown), .load(load),
        .load_val(load_val), .count(count0), .tc(tc0), .seg(seg0), .an(an0));

    bcd_updown_display #(.DIGITS(2), .MAX_COUNT(59), .SCAN_DIV(4)) u1 (
        .clk(clk), .reset(reset), .en(en), .updown(updown), .load(load),
        .load_val(load_val), .count(count1), .tc(tc1), .seg(seg1), .an(an1));

    typedef struct {
        logic       ld;
        logic       en;
        logic       ud;
        logic [7:0] val;
        logic [7:0] exp_cnt;
        logic       exp_tc;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [7:0] to_bcd2(input int n);
        logic [7:0] r;
        r[3:0] = 4'(n % 10);
        r[7:4] = 4'((n / 10) % 10);
        return r;
    endfunction

    function automatic logic [7:0] exp_seg(input logic [3:0] d);
        case (d)
            4'd0: return 8'h03;
            4'd1: return 8'h9F;
            4'd2: return 8'h25;
            4'd3: return 8'h0D;
            4'd4: return 8'h99;
            4'd5: return 8'h49;
            4'd6: return 8'h41;
            4'd7: return 8'h1F;
            4'd8: return 8'h01;
            4'd9: return 8'h09;
            default: return 8'hFF;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        edges++;
    endtask

    task automatic set_in(input logic ld, input logic e, input logic ud, input logic [7:0] v);
        load     = ld;
        en       = e;
        updown   = ud;
        load_val = v;
    endtask

    // Scan position predicted from edges since reset release (SCAN_DIV=4, 2 digits).
    function automatic int scan_idx();
        return (edges / 4) % 2;
    endfunction

    initial begin
        logic [7:0] dvals[3];
        logic [7:0] exp_d1;
        int         idx;

        vecs[0]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h99, 1'b1};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 8'h10, 8'h10, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h09, 1'b0};
        vecs[3]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h10, 1'b0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 8'h47, 8'h47, 1'b0};
        vecs[5]  = '{1'b1, 1'b1, 1'b0, 8'h3A, 8'h47, 1'b0};
        vecs[6]  = '{1'b1, 1'b1, 1'b1, 8'hA0, 8'h47, 1'b0};
        vecs[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, 8'h47, 1'b0};
        vecs[8]  = '{1'b1, 1'b1, 1'b1, 8'h99, 8'h99, 1'b0};
        vecs[9]  = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1};
        vecs[10] = '{1'b1, 1'b0, 1'b0, 8'h01, 8'h01, 1'b0};
        vecs[11] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h00, 1'b0};
        vecs[12] = '{1'b0, 1'b1, 1'b1, 8'h00, 8'h99, 1'b1};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 8'h00, 8'h00, 1'b1};

        reset = 1'b1;
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        #12;
        check("reset_count", 32'(count0), 32'h00);
        check("reset_tc", 32'(tc0), 32'h0);
        check("reset_an", 32'(an0), 32'h2);
        check("reset_seg", 32'(seg0), 32'h03);
        reset = 1'b0;
        edges = 0;

        // Full up sweep on both terminal counts.
        set_in(1'b0, 1'b1, 1'b0, 8'h00);
        for (int k = 1; k <= 100; k++) begin
            step();
            check("up99_count", 32'(count0), 32'(to_bcd2(k % 100)));
            check("up99_tc", 32'(tc0), 32'(k == 100));
            check("up59_count", 32'(count1), 32'(to_bcd2(k % 60)));
            check("up59_tc", 32'(tc1), 32'(k == 60));
        end

        for (int v = 0; v < 14; v++) begin
            set_in(vecs[v].ld, vecs[v].en, vecs[v].ud, vecs[v].val);
            step();
            check($sformatf("vec%0d_count", v), 32'(count0), 32'(vecs[v].exp_cnt));
            check($sformatf("vec%0d_tc", v), 32'(tc0), 32'(vecs[v].exp_tc));
        end

        // Terminal value 59: out-of-range load rejected, wraps in both directions.
        set_in(1'b1, 1'b0, 1'b0, 8'h59);
        step();
        check("m59_load59", 32'(count1), 32'h59);
        set_in(1'b1, 1'b1, 1'b0, 8'h60);
        step();
        check("m59_load60_ignored", 32'(count1), 32'h59);
        check("m99_load60_taken", 32'(count0), 32'h60);
        set_in(1'b0, 1'b1, 1'b0, 8'h00);
        step();
        check("m59_wrap_up", 32'(count1), 32'h00);
        check("m59_wrap_up_tc", 32'(tc1), 32'h1);
        check("m99_no_tc", 32'(tc0), 32'h0);
        set_in(1'b0, 1'b1, 1'b1, 8'h00);
        step();
        check("m59_wrap_dn", 32'(count1), 32'h59);
        check("m59_wrap_dn_tc", 32'(tc1), 32'h1);
        check("m99_dn_count", 32'(count0), 32'h60);

        // Hold at 47 while the display scans.
        set_in(1'b1, 1'b0, 1'b0, 8'h47);
        step();
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        step();
        for (int k = 0; k < 20; k++) begin
            step();
            idx = scan_idx();
            check("hold_count", 32'(count0), 32'h47);
            check("hold_tc", 32'(tc0), 32'h0);
            check("scan_an", 32'(an0), (idx == 0) ? 32'h2 : 32'h1);
            check("scan_seg", 32'(seg0), 32'(exp_seg((idx == 0) ? 4'd7 : 4'd4)));
        end

        // Leading-zero handling on the upper digit.
        dvals[0] = 8'h05;
        dvals[1] = 8'h50;
        dvals[2] = 8'h00;
        for (int j = 0; j < 3; j++) begin
            set_in(1'b1, 1'b0, 1'b0, dvals[j]);
            step();
            set_in(1'b0, 1'b0, 1'b0, 8'h00);
            step();
`ifdef BCD_DISP_LZ_BLANK_EN
            exp_d1 = (dvals[j][7:4] == 4'd0) ? 8'hFF : exp_seg(dvals[j][7:4]);
`else
            exp_d1 = exp_seg(dvals[j][7:4]);
`endif
            for (int k = 0; k < 8; k++) begin
                step();
                idx = scan_idx();
                check($sformatf("lz_seg_%02h", dvals[j]), 32'(seg0),
                      (idx == 0) ? 32'(exp_seg(dvals[j][3:0])) : 32'(exp_d1));
            end
        end

        // Asynchronous reset mid-cycle while digit 1 of 0x63 is displayed.
        set_in(1'b1, 1'b0, 1'b0, 8'h63);
        step();
        set_in(1'b0, 1'b0, 1'b0, 8'h00);
        step();
        for (int k = 0; k < 10 && an0 != 2'b01; k++) step();
        check("pre_rst_an", 32'(an0), 32'h1);
        check("pre_rst_seg", 32'(seg0), 32'(exp_seg(4'd6)));
        #2;
        reset = 1'b1;
        #1;
        check("arst_count", 32'(count0), 32'h00);
        check("arst_tc", 32'(tc0), 32'h0);
        check("arst_an", 32'(an0), 32'h2);
        check("arst_seg", 32'(seg0), 32'h03);
        @(posedge clk);
        #3;
        reset = 1'b0;
        edges = 0;
        step();
        check("post_rst_count", 32'(count0), 32'h00);
        check("post_rst_an", 32'(an0), 32'h2);

        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/bcd_updown_display.md
# bcd_updown_display

Parametrised multi-digit BCD up/down counter with a built-in time-multiplexed seven-segment display driver. It generalises the fixed two-digit 0–99 counter in two ways:
- digit count and terminal count are parameters;
- it adds a count enable, synchronous load and a wrap pulse.

It sits between board-level control inputs (buttons or tick generators) and the seven-segment anode/segment pins.

## Interface
Parameters:
- `DIGITS`, 2, number of BCD digits (1–8).
- `MAX_COUNT`, 99, decimal terminal value; must be < 10^DIGITS.
- `SCAN_DIV`, 1000, clk cycles each digit is driven (≥ 2).

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous, active-high; clock `clk`.
- `en`  in  1  count-step qualifier, sampled each clk edge.
- `updown`  in  1  0 = count up, 1 = count down.
- `load`  in  1  synchronous load strobe.
- `load_val`  in  4*DIGITS  BCD value to load; digit 0 is in [3:0].
- `count`  out  4*DIGITS  registered BCD count; digit 0 is in [3:0].
- `tc`  out  1  one-cycle pulse on wrap.
- `seg`  out  8  active-low segments, bit order {a,b,c,d,e,f,g,dp}; dp is always 1 (off).
- `an`  out  DIGITS  active-low digit enables, exactly one low.

## Operation
Priority per edge: reset > load > en > hold.

Load:
- Accepted only if every nibble is ≤ 9 and the value is ≤ MAX_COUNT.
- An invalid load is ignored: count holds and it does not fall through to en.
- A valid load never asserts tc.

Up step (en=1, updown=0):
- count == MAX_COUNT → 0, tc=1.
- Otherwise +1 with decimal carry ripple (nibble 9 → 0, carry into the next digit).

Down step (en=1, updown=1):
- count == 0 → MAX_COUNT, tc=1.
- Otherwise −1 with decimal borrow (nibble 0 → 9, borrow from the next digit).

tc:
- Registered; high exactly in the cycle in which the wrapped count value appears.
- Otherwise 0.

Scan logic:
- Prescaler counts 0..SCAN_DIV−1. At its terminal value, the digit index advances 0 → 1 → … → DIGITS−1 → 0.
- `an` = ~(1 << index).
- `seg` = decode of count nibble[index].

Decode (active low):
- 0 = 00000011, 1 = 10011111, 2 = 00100101, 3 = 00001101, 4 = 10011001
- 5 = 01001001, 6 = 01000001, 7 = 00011111, 8 = 00000001, 9 = 00001001
- 10–15 (unreachable) = 11111111.

Reset: count=0, tc=0, prescaler=0, index=0, an=~1, seg=00000011. All registers clear immediately, without a clock edge.

## Timing
- count/tc latency: 1 clk from the sampled en/load.
- seg and an are both registered from the same index and nibble, so they change on the same edge; no cycle exists where an and seg refer to different digits.
- seg tracks a count change 1 clk after count updates (decode register).
- Each digit is active for exactly SCAN_DIV cycles; full refresh period is DIGITS*SCAN_DIV cycles.
- Reset deassertion: first prescaler increment happens on the first clk edge after release.

## Configuration
Macro: `BCD_DISP_LZ_BLANK_EN`.
- Defined: leading-zero blanking. Digit i (i ≥ 1) outputs seg=11111111 while nibbles i..DIGITS−1 are all 0. Digit 0 is never blanked. `an` scanning is unchanged.
- Undefined: all digits always show their decoded value, including leading zeros.

## Test plan
Default DIGITS=2, MAX_COUNT=99, SCAN_DIV=4, macro undefined unless stated.

1. Reset, then hold en=1 with updown=0 for 100 cycles → count 0x00, 0x01 … 0x09, 0x10 … 0x99, then 0x00; tc high exactly once, coincident with 0x99 → 0x00. Repeat with MAX_COUNT=59 → 0x59 → 0x00 with tc.
2. From 0x00, en=1, updown=1 → 0x99 with tc=1. From 0x10, one step → 0x09, tc=0.
3. load=1, load_val=0x47, en=1 on the same edge → count 0x47, tc=0. Then load_val=0x3A → ignored, count stays 0x47. With MAX_COUNT=59, load_val=0x60 → ignored.
4. en=0, load=0 for 20 cycles at 0x47 → count constant, tc=0. Meanwhile an alternates 10/01 every 4 cycles, seg 10011001 (4) on digit 1 and 00011111 (7) on digit 0.
5. count=0x05 with `BCD_DISP_LZ_BLANK_EN` defined → digit 1 seg=11111111, digit 0 seg=01001001. Without the macro → digit 1 seg=00000011.
6. Assert reset asynchronously mid-cycle at count 0x63 → count=0x00, tc=0, an=10, seg=00000011 before the next clk edge.
